// File: rtl/fifo_uart_tx_pkg.sv
//==============================================================================
// fifo_uart_pkg : shared types and helpers for the FIFO-to-UART drain stage.
// Rev 1.0
//==============================================================================
`default_nettype none

package fifo_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      LATCH  = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;

`ifdef FIFO_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
//==============================================================================
// baud_tick_gen : bit-period counter, one-cycle tick at count BAUD_DIV-1.
// Rev 1.0
//==============================================================================
`default_nettype none

module baud_tick_gen #(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);

   localparam int c_CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

   logic [c_CW-1:0] r_cnt;
   logic            w_last;

   assign w_last = (r_cnt == c_CW'(BAUD_DIV - 1));
   assign o_tick = w_last;

   always_ff @(posedge clk) begin
      if (rst || i_clr || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/fifo_uart_tx.sv
//==============================================================================
// fifo_uart_tx : pops bytes from a FIFO and sends them as UART 8N1, LSB first.
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined. Rev 1.0
//==============================================================================
`default_nettype none

module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DW       = 8,
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fifo_empty,
   input  logic          fifo_rd_busy,
   input  logic [DW-1:0] fifo_dout,
   output logic          fifo_rd_en,
   output logic          tx,
   output logic          busy,
   output logic [15:0]   byte_cnt
);

   localparam int c_BAUD_DIV = baud_div(CLK_FREQ, BAUD);

   if (DW != 8) begin : g_dw_check
      $error("fifo_uart_tx: DW must be 8");
   end
   if (c_BAUD_DIV < 2) begin : g_baud_check
      $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 2");
   end

   state_t          r_state;
   logic [DW-1:0]   r_shift;
   logic [2:0]      r_bit_idx;
   logic            r_tx;
   logic            r_rd_en;
   logic [15:0]     r_byte_cnt;
   logic            w_tick;
   logic            w_clr;
`ifdef FIFO_UART_TX_PARITY_EN
   logic            r_par;
`endif

   // Bit timing restarts on the edge that enters START.
   assign w_clr = (r_state == LATCH);

   baud_tick_gen #(
      .BAUD_DIV (c_BAUD_DIV)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_idx  <= 3'd0;
         r_tx       <= 1'b1;
         r_rd_en    <= 1'b0;
         r_byte_cnt <= 16'd0;
`ifdef FIFO_UART_TX_PARITY_EN
         r_par      <= 1'b0;
`endif
      end else begin
         r_rd_en <= 1'b0;
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (!fifo_empty && !fifo_rd_busy) begin
                  r_state <= FETCH;
                  r_rd_en <= 1'b1;
               end
            end
            FETCH: begin
               r_state <= LATCH;
            end
            LATCH: begin
               r_shift   <= fifo_dout;
               r_bit_idx <= 3'd0;
               r_tx      <= 1'b0;
               r_state   <= START;
`ifdef FIFO_UART_TX_PARITY_EN
               r_par     <= ^fifo_dout;
`endif
            end
            START: begin
               if (w_tick) begin
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[DW-1:1]};
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     r_tx    <= r_par;
                     r_state <= PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= STOP;
`endif
                  end else begin
                     r_tx      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[DW-1:1]};
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (w_tick) begin
                  r_tx    <= 1'b1;
                  r_state <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_tick) begin
                  r_byte_cnt <= r_byte_cnt + 16'd1;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign fifo_rd_en = r_rd_en;
   assign tx         = r_tx;
   assign busy       = (r_state != IDLE);
   assign byte_cnt   = r_byte_cnt;

endmodule

`default_nettype wire
